// File: rtl/req_to_ahb_master.sv
// Valid/ready request stream to pipelined AHB-lite single transfers (address stage A, data stage D).
// Optional local alignment rejection is enabled with `define REQ_TO_AHB_ALIGN_CHECK_EN.
module req_to_ahb_master #(
  parameter int AW = 12
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [2:0]    req_size,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          HSEL,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic [2:0]    HSIZE,
  output logic          HWRITE,
  output logic [31:0]   HWDATA,
  input  logic          HREADY,
  input  logic [31:0]   HRDATA,
  input  logic          HRESP
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic          r_a_valid;
  logic          r_a_write;
  logic [AW-1:0] r_a_addr;
  logic [2:0]    r_a_size;
  logic [31:0]   r_a_wdata;
  logic          r_a_bad;

  logic          r_d_valid;
  logic          r_d_write;
  logic [31:0]   r_d_wdata;
  logic          r_d_bad;

  logic          r_rsp_valid;
  logic [31:0]   r_rsp_rdata;
  logic          r_rsp_err;

  logic          w_cancel;
  logic          w_accept;
  logic          w_req_bad;

`ifdef REQ_TO_AHB_ALIGN_CHECK_EN
  function automatic logic f_misaligned(input logic [1:0] addr_lo, input logic [2:0] size);
    logic bad;
    case (size)
      3'd0:    bad = 1'b0;
      3'd1:    bad = addr_lo[0];
      3'd2:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  assign w_req_bad = f_misaligned(req_addr[1:0], req_size);
`else
  assign w_req_bad = 1'b0;
`endif

  // Cancel covers both cycles of a two-cycle ERROR response on a real transfer in D.
  assign w_cancel  = r_d_valid && !r_d_bad && HRESP;
  assign req_ready = !r_a_valid || (HREADY && !w_cancel);
  assign w_accept  = req_valid && req_ready;

  assign HSEL   = r_a_valid;
  assign HADDR  = r_a_addr;
  assign HSIZE  = r_a_size;
  assign HWRITE = r_a_write;
  assign HTRANS = (r_a_valid && !w_cancel && !r_a_bad) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HWDATA = (r_d_valid && r_d_write) ? r_d_wdata : 32'h0000_0000;

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  // Address stage: load on handshake, drain when the address phase completes, retain on cancel.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_a_valid <= 1'b0;
      r_a_write <= 1'b0;
      r_a_addr  <= '0;
      r_a_size  <= 3'd0;
      r_a_wdata <= 32'h0000_0000;
      r_a_bad   <= 1'b0;
    end else if (w_accept) begin
      r_a_valid <= 1'b1;
      r_a_write <= req_write;
      r_a_addr  <= req_addr;
      r_a_size  <= req_size;
      r_a_wdata <= req_wdata;
      r_a_bad   <= w_req_bad;
    end else if (HREADY && !w_cancel) begin
      r_a_valid <= 1'b0;
    end
  end

  // Data stage: advances only when the slave completes the current phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_d_valid <= 1'b0;
      r_d_write <= 1'b0;
      r_d_wdata <= 32'h0000_0000;
      r_d_bad   <= 1'b0;
    end else if (HREADY) begin
      r_d_valid <= r_a_valid && !w_cancel;
      r_d_write <= r_a_write;
      r_d_wdata <= r_a_wdata;
      r_d_bad   <= r_a_bad;
    end
  end

  // Response pulse; locally rejected entries complete as errors with zero data.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0000_0000;
      r_rsp_err   <= 1'b0;
    end else if (r_d_valid && HREADY) begin
      r_rsp_valid <= 1'b1;
      r_rsp_rdata <= (r_d_write || r_d_bad) ? 32'h0000_0000 : HRDATA;
      r_rsp_err   <= HRESP || r_d_bad;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0000_0000;
      r_rsp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_req_to_ahb_master.sv
// Self-checking bench for req_to_ahb_master: scoreboarded responses against a small AHB slave model
// with programmable wait states and two-cycle ERROR injection.
module tb_req_to_ahb_master;
  localparam int AW = 12;
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] NSEQ = 2'b10;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [2:0]    req_size = 3'd0;
  logic [31:0]   req_wdata = 32'h0;
  logic          req_ready;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          HSEL;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic [31:0]   HWDATA;
  logic          HREADY = 1'b1;
  logic [31:0]   HRDATA = 32'h0;
  logic          HRESP = 1'b0;

  typedef struct packed { logic [31:0] rdata; logic err; } exp_t;
  typedef struct packed { logic [31:0] rdata; logic err; int cyc; } act_t;
  typedef struct packed { logic [AW-1:0] addr; logic wr; int cyc; } beat_t;

  exp_t  exp_q[$];
  act_t  act_q[$];
  beat_t beat_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int nseq_cnt = 0;
  int err_first_cnt = 0;
  int bad_err_htrans = 0;

  // slave model state and test controls
  logic          dp_valid = 1'b0;
  logic          dp_write = 1'b0;
  logic [AW-1:0] dp_addr = '0;
  logic          err_phase = 1'b0;
  int            err_count = 0;
  logic [31:0]   smem [0:1023];
  logic [1023:0] smem_wr = '0;
  logic [AW-1:0] err_addr = 12'hFFF;
  int            err_budget = 0;
  int            stall_cyc = -1;

  req_to_ahb_master #(.AW(AW)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  function automatic logic [31:0] init_word(input logic [9:0] idx);
    return 32'hC0DE_0000 | {22'h0, idx};
  endfunction

  function automatic logic [31:0] rd_word(input logic [AW-1:0] a);
    return smem_wr[a[11:2]] ? smem[a[11:2]] : init_word(a[11:2]);
  endfunction

  // slave state: data-phase capture and memory write
  always @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid  <= 1'b0;
      err_phase <= 1'b0;
      smem_wr   <= '0;
    end else begin
      err_phase <= HRESP && !HREADY;
      if (HRESP && !HREADY) err_count <= err_count + 1;
      if (HREADY) begin
        if (dp_valid && dp_write && !HRESP) begin
          smem[dp_addr[11:2]]    <= HWDATA;
          smem_wr[dp_addr[11:2]] <= 1'b1;
        end
        dp_valid <= HSEL && (HTRANS == NSEQ);
        dp_write <= HWRITE;
        dp_addr  <= HADDR;
      end
    end
  end

  // slave response driven away from the active edge
  always @(negedge HCLK) begin
    if (err_phase) begin
      HREADY = 1'b1; HRESP = 1'b1; HRDATA = 32'h0;
    end else if (dp_valid && dp_addr == err_addr && err_count < err_budget) begin
      HREADY = 1'b0; HRESP = 1'b1; HRDATA = 32'h0;
    end else begin
      HREADY = (cyc != stall_cyc);
      HRESP  = 1'b0;
      HRDATA = (dp_valid && !dp_write) ? rd_word(dp_addr) : 32'h0;
    end
  end

  // bus monitor
  always @(posedge HCLK) begin
    cyc <= cyc + 1;
    if (!HRESET && HTRANS == NSEQ) begin
      nseq_cnt <= nseq_cnt + 1;
      if (HREADY) beat_q.push_back('{HADDR, HWRITE, cyc});
    end
    if (!HRESET && HRESP && !HREADY) begin
      err_first_cnt <= err_first_cnt + 1;
      if (HTRANS != IDLE) bad_err_htrans <= bad_err_htrans + 1;
    end
  end

  // response collector
  always @(negedge HCLK) begin
    if (rsp_valid) act_q.push_back('{rsp_rdata, rsp_err, cyc});
  end

  task automatic send(input logic w, input logic [AW-1:0] a, input logic [2:0] s,
                      input logic [31:0] d, output int acc);
    int n;
    req_write = w; req_addr = a; req_size = s; req_wdata = d; req_valid = 1'b1;
    #1;
    acc = -1;
    n = 0;
    while (!req_ready && n < 40) begin
      @(negedge HCLK); #1;
      n++;
    end
    if (req_ready) acc = cyc;
    @(negedge HCLK);
  endtask

  task automatic wait_rsp(input int n);
    int k;
    k = 0;
    while (act_q.size() < n && k < 200) begin
      @(negedge HCLK); #1;
      k++;
    end
    repeat (3) @(negedge HCLK);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;
    #1;
    n_cmp++;
    if ({HSEL, HTRANS, HWRITE, HSIZE, HADDR} !== '0) begin
      n_bad++; $display("FAIL reset_addr_phase: got sel=%b trans=%b wr=%b size=%0d addr=%h want all 0", HSEL, HTRANS, HWRITE, HSIZE, HADDR);
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) begin
      n_bad++; $display("FAIL reset_rsp: got v=%b e=%b d=%h want 0", rsp_valid, rsp_err, rsp_rdata);
    end
    n_cmp++;
    if (HWDATA !== 32'h0) begin n_bad++; $display("FAIL reset_hwdata: got %h want 0", HWDATA); end
    @(negedge HCLK);
  endtask

  task automatic test_write_read();
    int acc_w, acc_r, base_n, i;
    exp_t e;
    act_t a;
    beat_q.delete();
    base_n = nseq_cnt;
    send(1'b1, 12'h010, 3'd2, 32'hDEADBEEF, acc_w);
    exp_q.push_back('{32'h0, 1'b0});
    send(1'b0, 12'h010, 3'd2, 32'h0, acc_r);
    exp_q.push_back('{32'hDEADBEEF, 1'b0});
    req_valid = 1'b0;
    wait_rsp(2);
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (act_q.size() == 0) begin
        n_bad++; $display("FAIL wr_rd_rsp%0d: got no response want d=%h e=%b", i, e.rdata, e.err);
      end else begin
        a = act_q.pop_front();
        if ({a.rdata, a.err} !== {e.rdata, e.err}) begin
          n_bad++; $display("FAIL wr_rd_rsp%0d: got d=%h e=%b want d=%h e=%b", i, a.rdata, a.err, e.rdata, e.err);
        end
        if (i == 0) begin
          n_cmp++;
          if (a.cyc - acc_w !== 3) begin n_bad++; $display("FAIL wr_latency: got %0d want 3", a.cyc - acc_w); end
        end
      end
      i++;
    end
    n_cmp++;
    if (act_q.size() != 0) begin n_bad++; $display("FAIL wr_rd_extra: got %0d extra want 0", act_q.size()); act_q.delete(); end
    n_cmp++;
    if (nseq_cnt - base_n !== 2 || beat_q.size() != 2) begin
      n_bad++; $display("FAIL wr_rd_nonseq: got cycles=%0d beats=%0d want 2/2", nseq_cnt - base_n, beat_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int acc, acc0, i;
    exp_t e;
    act_t a;
    logic [AW-1:0] ad;
    beat_q.delete();
    acc0 = -1;
    for (int k = 0; k < 8; k++) begin
      ad = 12'h200 + 12'(4 * k);
      send(1'b0, ad, 3'd2, 32'h0, acc);
      if (k == 0) acc0 = acc;
      exp_q.push_back('{init_word(ad[11:2]), 1'b0});
    end
    req_valid = 1'b0;
    wait_rsp(8);
    n_cmp++;
    if (beat_q.size() != 8) begin n_bad++; $display("FAIL b2b_beats: got %0d want 8", beat_q.size()); end
    for (int k = 0; k < 8 && k < beat_q.size(); k++) begin
      n_cmp++;
      if (beat_q[k].addr !== 12'h200 + 12'(4 * k) || beat_q[k].cyc !== acc0 + 1 + k) begin
        n_bad++; $display("FAIL b2b_beat%0d: got addr=%h cyc=%0d want addr=%h cyc=%0d", k, beat_q[k].addr, beat_q[k].cyc, 12'h200 + 12'(4 * k), acc0 + 1 + k);
      end
    end
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (act_q.size() == 0) begin
        n_bad++; $display("FAIL b2b_rsp%0d: got no response want d=%h", i, e.rdata);
      end else begin
        a = act_q.pop_front();
        if ({a.rdata, a.err} !== {e.rdata, e.err} || a.cyc !== acc0 + 3 + i) begin
          n_bad++; $display("FAIL b2b_rsp%0d: got d=%h e=%b cyc=%0d want d=%h e=%b cyc=%0d", i, a.rdata, a.err, a.cyc, e.rdata, e.err, acc0 + 3 + i);
        end
      end
      i++;
    end
    n_cmp++;
    if (act_q.size() != 0) begin n_bad++; $display("FAIL b2b_extra: got %0d extra want 0", act_q.size()); act_q.delete(); end
  endtask

  task automatic test_stall();
    int acc_w, acc_r, i;
    exp_t e;
    act_t a;
    beat_q.delete();
    stall_cyc = cyc + 2;
    send(1'b1, 12'h020, 3'd2, 32'h12345678, acc_w);
    exp_q.push_back('{32'h0, 1'b0});
    send(1'b0, 12'h024, 3'd2, 32'h0, acc_r);
    exp_q.push_back('{init_word(10'd9), 1'b0});
    req_valid = 1'b0;
    #2;
    n_cmp++;
    if ({HREADY, req_ready, HTRANS, HWRITE, HADDR, HWDATA} !== {1'b0, 1'b0, NSEQ, 1'b0, 12'h024, 32'h12345678}) begin
      n_bad++; $display("FAIL stall_cycle: got rdy=%b rr=%b trans=%b wr=%b addr=%h wd=%h want 0 0 10 0 024 12345678", HREADY, req_ready, HTRANS, HWRITE, HADDR, HWDATA);
    end
    @(negedge HCLK); #2;
    n_cmp++;
    if ({HTRANS, HWRITE, HADDR, HWDATA} !== {NSEQ, 1'b0, 12'h024, 32'h12345678}) begin
      n_bad++; $display("FAIL stall_hold: got trans=%b wr=%b addr=%h wd=%h want 10 0 024 12345678", HTRANS, HWRITE, HADDR, HWDATA);
    end
    wait_rsp(2);
    stall_cyc = -1;
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (act_q.size() == 0) begin
        n_bad++; $display("FAIL stall_rsp%0d: got no response want d=%h", i, e.rdata);
      end else begin
        a = act_q.pop_front();
        if ({a.rdata, a.err} !== {e.rdata, e.err}) begin
          n_bad++; $display("FAIL stall_rsp%0d: got d=%h e=%b want d=%h e=%b", i, a.rdata, a.err, e.rdata, e.err);
        end
      end
      i++;
    end
    n_cmp++;
    if (act_q.size() != 0) begin n_bad++; $display("FAIL stall_extra: got %0d extra want 0", act_q.size()); act_q.delete(); end
    n_cmp++;
    if (beat_q.size() != 2) begin
      n_bad++; $display("FAIL stall_beats: got %0d want 2", beat_q.size());
    end else if (beat_q[0].addr !== 12'h020 || beat_q[1].addr !== 12'h024) begin
      n_bad++; $display("FAIL stall_beats: got %h,%h want 020,024", beat_q[0].addr, beat_q[1].addr);
    end
  endtask

  task automatic test_error();
    int acc, base_e, base_b, i;
    exp_t e;
    act_t a;
    beat_q.delete();
    base_e = err_first_cnt;
    base_b = bad_err_htrans;
    err_addr = 12'h104;
    err_budget = err_count + 1;
    send(1'b0, 12'h100, 3'd2, 32'h0, acc);
    exp_q.push_back('{init_word(10'h040), 1'b0});
    send(1'b0, 12'h104, 3'd2, 32'h0, acc);
    exp_q.push_back('{32'h0, 1'b1});
    send(1'b0, 12'h108, 3'd2, 32'h0, acc);
    exp_q.push_back('{init_word(10'h042), 1'b0});
    req_valid = 1'b0;
    wait_rsp(3);
    err_addr = 12'hFFF;
    n_cmp++;
    if (err_first_cnt - base_e !== 1 || bad_err_htrans - base_b !== 0) begin
      n_bad++; $display("FAIL err_htrans: got err_cycles=%0d non_idle=%0d want 1/0", err_first_cnt - base_e, bad_err_htrans - base_b);
    end
    n_cmp++;
    if (beat_q.size() != 3) begin
      n_bad++; $display("FAIL err_beats: got %0d want 3", beat_q.size());
    end else if (beat_q[0].addr !== 12'h100 || beat_q[1].addr !== 12'h104 || beat_q[2].addr !== 12'h108) begin
      n_bad++; $display("FAIL err_beats: got %h,%h,%h want 100,104,108", beat_q[0].addr, beat_q[1].addr, beat_q[2].addr);
    end
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (act_q.size() == 0) begin
        n_bad++; $display("FAIL err_rsp%0d: got no response want d=%h e=%b", i, e.rdata, e.err);
      end else begin
        a = act_q.pop_front();
        if ({a.rdata, a.err} !== {e.rdata, e.err}) begin
          n_bad++; $display("FAIL err_rsp%0d: got d=%h e=%b want d=%h e=%b", i, a.rdata, a.err, e.rdata, e.err);
        end
      end
      i++;
    end
    n_cmp++;
    if (act_q.size() != 0) begin n_bad++; $display("FAIL err_extra: got %0d extra want 0", act_q.size()); act_q.delete(); end
  endtask

  task automatic test_reset_mid();
    int acc;
    exp_t e;
    act_t a;
    send(1'b0, 12'h300, 3'd2, 32'h0, acc);
    req_valid = 1'b0;
    @(negedge HCLK);
    HRESET = 1'b1;
    @(negedge HCLK); #1;
    n_cmp++;
    if ({HTRANS, HSEL, rsp_valid, req_ready} !== {IDLE, 1'b0, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL rst_mid: got trans=%b sel=%b rsp_v=%b rdy=%b want 00 0 0 1", HTRANS, HSEL, rsp_valid, req_ready);
    end
    HRESET = 1'b0;
    repeat (5) @(negedge HCLK);
    n_cmp++;
    if (act_q.size() != 0) begin n_bad++; $display("FAIL rst_mid_dropped: got %0d responses want 0", act_q.size()); act_q.delete(); end
    send(1'b0, 12'h304, 3'd2, 32'h0, acc);
    exp_q.push_back('{init_word(10'h0C1), 1'b0});
    req_valid = 1'b0;
    wait_rsp(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (act_q.size() == 0) begin
        n_bad++; $display("FAIL rst_after: got no response want d=%h", e.rdata);
      end else begin
        a = act_q.pop_front();
        if ({a.rdata, a.err} !== {e.rdata, e.err} || a.cyc - acc !== 3) begin
          n_bad++; $display("FAIL rst_after: got d=%h e=%b lat=%0d want d=%h e=%b lat=3", a.rdata, a.err, a.cyc - acc, e.rdata, e.err);
        end
      end
    end
  endtask

  task automatic test_align();
    int acc, want_beats;
    exp_t e;
    act_t a;
    beat_q.delete();
    send(1'b0, 12'h002, 3'd2, 32'h0, acc);
`ifdef REQ_TO_AHB_ALIGN_CHECK_EN
    exp_q.push_back('{32'h0, 1'b1});
    want_beats = 0;
`else
    exp_q.push_back('{init_word(10'h000), 1'b0});
    want_beats = 1;
`endif
    req_valid = 1'b0;
    wait_rsp(1);
    n_cmp++;
    if (beat_q.size() != want_beats) begin
      n_bad++; $display("FAIL align_beats: got %0d want %0d", beat_q.size(), want_beats);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (act_q.size() == 0) begin
        n_bad++; $display("FAIL align_rsp: got no response want d=%h e=%b", e.rdata, e.err);
      end else begin
        a = act_q.pop_front();
        if ({a.rdata, a.err} !== {e.rdata, e.err} || a.cyc - acc !== 3) begin
          n_bad++; $display("FAIL align_rsp: got d=%h e=%b lat=%0d want d=%h e=%b lat=3", a.rdata, a.err, a.cyc - acc, e.rdata, e.err);
        end
      end
    end
    n_cmp++;
    if (act_q.size() != 0) begin n_bad++; $display("FAIL align_extra: got %0d extra want 0", act_q.size()); act_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_stall();
    test_error();
    test_reset_mid();
    test_align();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
